// File: rtl/char_r.sv
// ============================================================================
// Module   : char_r
// Brief    : Serial character receiver (idle-high line, start 0, MSB-first
//            data, stop 1) with a valid/ready holding register. Optional
//            input synchronizer enabled by macro CHAR_R_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module char_r #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_frame_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int                 c_bit_w    = $clog2(DATA_W + 1);
  localparam logic [7:0]         c_half     = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0]         c_last     = 8'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic w_rx;

`ifdef CHAR_R_SYNC_EN
  logic [1:0] r_sync;

  // Flops reset high so a reset never looks like a start bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], i_rx};
    end
  end

  assign w_rx = r_sync[1];
`else
  assign w_rx = i_rx;
`endif

  state_t              r_state,     w_state_nxt;
  logic [7:0]          r_clk_cnt,   w_clk_nxt;
  logic [c_bit_w-1:0]  r_bit_cnt,   w_bit_nxt;
  logic [DATA_W-1:0]   r_shift,     w_shift_nxt;
  logic [DATA_W-1:0]   r_data,      w_data_nxt;
  logic                r_valid,     w_valid_nxt;
  logic                r_frame_err, w_ferr_nxt;
  logic                r_overrun,   w_ovr_nxt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_clk_cnt   <= 8'd0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      r_overrun   <= w_ovr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clk_nxt   = r_clk_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid & ~i_ready;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = r_overrun;

    case (r_state)
      S_IDLE: begin
        if (!w_rx) begin
          w_bit_nxt = '0;
          w_clk_nxt = 8'd0;
          // With a zero half-bit wait the detecting cycle is the start sample.
          w_state_nxt = (c_half == 8'd0) ? S_DATA : S_START;
        end
      end

      S_START: begin
        if (r_clk_cnt + 8'd1 == c_half) begin
          w_clk_nxt   = 8'd0;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end else begin
          w_clk_nxt = r_clk_cnt + 8'd1;
        end
      end

      S_DATA: begin
        if (r_clk_cnt == c_last) begin
          w_clk_nxt   = 8'd0;
          w_shift_nxt = {r_shift[DATA_W-2:0], w_rx};
          w_bit_nxt   = r_bit_cnt + c_bit_w'(1);
          if (r_bit_cnt == c_last_bit) begin
            w_state_nxt = S_STOP;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 8'd1;
        end
      end

      S_STOP: begin
        if (r_clk_cnt == c_last) begin
          w_clk_nxt = 8'd0;
          if (w_rx) begin
            // A slot being drained this cycle counts as free.
            if (!r_valid || i_ready) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ovr_nxt = 1'b1;
            end
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_BREAK;
          end
        end else begin
          w_clk_nxt = r_clk_cnt + 8'd1;
        end
      end

      S_BREAK: begin
        if (w_rx) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;
  // The start-detecting cycle already counts as busy.
  assign o_busy      = (r_state != S_IDLE) | ~w_rx;

endmodule

`default_nettype wire
